// File: rtl/led_seq_pkg.sv
// Shared types, constants and step-period helper for the LED sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam logic [7:0] LED_RESET  = 8'h00;
    localparam logic [7:0] LED_FIRST  = 8'h01;
    localparam logic [7:0] LED_LAST   = 8'h80;
    localparam int         NUM_SPEEDS = 4;

    // Clock cycles per pattern step at the given speed index.
    function automatic int unsigned step_period(input int unsigned clk_hz,
                                                input int unsigned base_hz,
                                                input logic [1:0]  speed);
        return clk_hz / (base_hz << speed);
    endfunction

endpackage

// File: rtl/led_seq_ctrl_sync_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer.
module sync_debounce #(
    parameter int   DEB_CYCLES = 1_000_000,
    parameter logic RESET_VAL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          meta_r;
    logic          sync_r;
    logic          dout_r;
    logic [CW-1:0] cnt_r;

    // Synchronize, then accept the synced value after DEB_CYCLES mismatching samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
            dout_r <= RESET_VAL;
            cnt_r  <= {CW{1'b0}};
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            if (sync_r == dout_r) begin
                cnt_r <= {CW{1'b0}};
            end else if (cnt_r == CW'(DEB_CYCLES - 1)) begin
                dout_r <= sync_r;
                cnt_r  <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign dout = dout_r;

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer controller: input conditioning, step prescaler and pattern FSM.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BASE_STEP_HZ = 4,
    parameter int DEB_CYCLES   = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw0,
    input  logic       key_n,
    output logic [7:0] led,
    output logic       step_en,
    output logic       mode,
    output logic [1:0] speed,
    output logic       blank
);
    localparam int PW = $clog2(CLK_HZ / BASE_STEP_HZ) + 1;

    logic          sw_db_s;
    logic          key_db_s;
    logic          key_db_d_r;
    logic          key_fall_s;
    logic [PW-1:0] presc_r;
    logic [PW-1:0] period_m1_s;
    logic          tc_s;
    logic          step_s;
    logic          pend_s;
    logic          step_en_r;
    logic [1:0]    speed_r;
    state_t        state_r;
    logic [7:0]    led_r;
    logic          mode_r;
    logic          blank_r;
    logic          dir_left_r;

    sync_debounce #(.DEB_CYCLES(DEB_CYCLES), .RESET_VAL(1'b0)) u_sw_deb (
        .clk  (clk),
        .rst  (rst),
        .din  (sw0),
        .dout (sw_db_s)
    );

    sync_debounce #(.DEB_CYCLES(DEB_CYCLES), .RESET_VAL(1'b1)) u_key_deb (
        .clk  (clk),
        .rst  (rst),
        .din  (key_n),
        .dout (key_db_s)
    );

    // Step event decode; a speed change suppresses a coincident terminal count.
    always_comb begin
        period_m1_s = PW'(step_period(CLK_HZ, BASE_STEP_HZ, speed_r) - 32'd1);
        key_fall_s  = key_db_d_r & ~key_db_s;
        tc_s        = (presc_r == period_m1_s);
        step_s      = tc_s & ~key_fall_s;
        pend_s      = (sw_db_s != mode_r);
    end

    // Prescaler, speed selection and registered step pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_db_d_r <= 1'b1;
            presc_r    <= {PW{1'b0}};
            speed_r    <= 2'd0;
            step_en_r  <= 1'b0;
        end else begin
            key_db_d_r <= key_db_s;
            step_en_r  <= step_s;
            if (key_fall_s) begin
                presc_r <= {PW{1'b0}};
                speed_r <= (speed_r == 2'(NUM_SPEEDS - 1)) ? 2'd0 : speed_r + 2'd1;
            end else if (tc_s) begin
                presc_r <= {PW{1'b0}};
            end else begin
                presc_r <= presc_r + PW'(1);
            end
        end
    end

    // Pattern FSM; advances only on step events so outputs change with step_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            led_r      <= LED_RESET;
            mode_r     <= 1'b0;
            blank_r    <= 1'b0;
            dir_left_r <= 1'b1;
        end else if (step_s) begin
            case (state_r)
                IDLE, BLANK: begin
                    mode_r     <= sw_db_s;
                    dir_left_r <= 1'b1;
                    led_r      <= LED_FIRST;
                    blank_r    <= 1'b0;
                    state_r    <= RUN;
                end
                RUN: begin
                    if (pend_s) begin
                        state_r <= BLANK;
                        led_r   <= LED_RESET;
                        blank_r <= 1'b1;
                    end else if (mode_r) begin
                        led_r <= {led_r[6:0], led_r[7]};
                    end else if (dir_left_r) begin
                        // Reverse at the end without repeating the end LED.
                        if (led_r == LED_LAST) begin
                            dir_left_r <= 1'b0;
                            led_r      <= {1'b0, led_r[7:1]};
                        end else begin
                            led_r <= {led_r[6:0], 1'b0};
                        end
                    end else begin
                        if (led_r == LED_FIRST) begin
                            dir_left_r <= 1'b1;
                            led_r      <= {led_r[6:0], 1'b0};
                        end else begin
                            led_r <= {1'b0, led_r[7:1]};
                        end
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    led_r      <= LED_RESET;
                    blank_r    <= 1'b0;
                    dir_left_r <= 1'b1;
                end
            endcase
        end
    end

    assign led     = led_r;
    assign step_en = step_en_r;
    assign mode    = mode_r;
    assign speed   = speed_r;
    assign blank   = blank_r;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench: directed scenarios plus random stimulus against a behavioural model.
module tb_led_seq_ctrl;
    localparam int CLK_HZ = 64;
    localparam int BASE   = 4;
    localparam int DEB    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw0 = 1'b0;
    logic       key_n = 1'b1;
    logic [7:0] led;
    logic       step_en;
    logic       mode;
    logic [1:0] speed;
    logic       blank;

    int compared   = 0;
    int mismatched = 0;

    // Model state: phase 0=idle, 1=running, 2=blank step; k = steps since pattern start.
    int           m_phase;
    int           m_k;
    int           m_cnt;
    bit           m_mode;
    bit           m_step;
    bit [1:0]     m_speed;
    bit           m_db[2];
    bit           m_kdb_prev;
    bit           m_dly[2][2];
    bit [DEB-1:0] m_win[2];
    int           m_age[2];

    always #5 clk = ~clk;

    led_seq_ctrl #(.CLK_HZ(CLK_HZ), .BASE_STEP_HZ(BASE), .DEB_CYCLES(DEB)) dut (
        .clk     (clk),
        .rst     (rst),
        .sw0     (sw0),
        .key_n   (key_n),
        .led     (led),
        .step_en (step_en),
        .mode    (mode),
        .speed   (speed),
        .blank   (blank)
    );

    function automatic int period(input bit [1:0] s);
        return CLK_HZ / (BASE << s);
    endfunction

    // Walk: one-hot rotating over 8 positions. Bounce: 14-step triangle 0..7..1.
    function automatic logic [7:0] pattern(input bit md, input int k);
        int p;
        int idx;
        if (md) begin
            idx = k % 8;
        end else begin
            p   = k % 14;
            idx = (p < 8) ? p : 14 - p;
        end
        return 8'h01 << idx;
    endfunction

    task automatic model_reset();
        m_phase    = 0;
        m_k        = 0;
        m_cnt      = 0;
        m_mode     = 1'b0;
        m_step     = 1'b0;
        m_speed    = 2'd0;
        m_db[0]    = 1'b0;
        m_db[1]    = 1'b1;
        m_kdb_prev = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_dly[0][i] = 1'b0;
            m_dly[1][i] = 1'b1;
            m_win[i]    = '0;
            m_age[i]    = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: sample inputs before the edge, advance the model, compare after the edge.
    task automatic tick();
        bit r_sw;
        bit r_key;
        bit r_rst;
        bit syn[2];
        bit fall;
        bit pend;
        r_sw  = sw0;
        r_key = key_n;
        r_rst = rst;
        @(posedge clk);
        #1;
        if (r_rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) syn[i] = m_dly[i][1];
            m_dly[0][1] = m_dly[0][0];
            m_dly[0][0] = r_sw;
            m_dly[1][1] = m_dly[1][0];
            m_dly[1][0] = r_key;
            fall   = m_kdb_prev & ~m_db[1];
            pend   = (m_db[0] != m_mode);
            m_step = 1'b0;
            if (fall) begin
                m_cnt   = 0;
                m_speed = m_speed + 2'd1;
            end else if (m_cnt == period(m_speed) - 1) begin
                m_cnt  = 0;
                m_step = 1'b1;
            end else begin
                m_cnt++;
            end
            if (m_step) begin
                if (m_phase == 1) begin
                    if (pend) m_phase = 2;
                    else      m_k++;
                end else begin
                    m_mode  = m_db[0];
                    m_phase = 1;
                    m_k     = 0;
                end
            end
            m_kdb_prev = m_db[1];
            for (int i = 0; i < 2; i++) begin
                m_win[i] = {m_win[i][DEB-2:0], syn[i]};
                m_age[i]++;
                if (m_age[i] >= DEB && m_win[i] == {DEB{~m_db[i]}}) begin
                    m_db[i]  = ~m_db[i];
                    m_age[i] = 0;
                end
            end
        end
        chk("led", led, (m_phase == 1) ? pattern(m_mode, m_k) : 8'h00);
        chk("step_en", {7'd0, step_en}, {7'd0, m_step});
        chk("mode", {7'd0, mode}, {7'd0, m_mode});
        chk("speed", {6'd0, speed}, {6'd0, m_speed});
        chk("blank", {7'd0, blank}, {7'd0, (m_phase == 2)});
    endtask

    task automatic wait_step(input string tag);
        int n;
        n = 0;
        while (!step_en && n < 40) begin
            tick();
            n++;
        end
        chk(tag, {7'd0, step_en}, 8'd1);
    endtask

    initial begin
        int n;
        model_reset();
        // Reset, then walk mode from release.
        rst = 1'b1;
        sw0 = 1'b1;
        repeat (3) tick();
        chk("rst_led", led, 8'h00);
        chk("rst_speed", {6'd0, speed}, 8'd0);
        chk("rst_step", {7'd0, step_en}, 8'd0);
        rst = 1'b0;
        repeat (15) tick();
        chk("first_step_early", {7'd0, step_en}, 8'd0);
        tick();
        chk("first_step", {7'd0, step_en}, 8'd1);
        chk("first_led", led, 8'h01);
        repeat (150) tick();
        // Drop to bounce mid-period: blank step, then bounce from 01.
        repeat (5) tick();
        sw0 = 1'b0;
        repeat (60) tick();
        // Bounce from reset for 16+ steps.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (16 * 17) tick();
        // Short glitch and a toggle that reverts before the next step.
        wait_step("wait_step_a");
        sw0 = 1'b1;
        repeat (3) tick();
        sw0 = 1'b0;
        repeat (20) tick();
        wait_step("wait_step_b");
        sw0 = 1'b1;
        repeat (6) tick();
        sw0 = 1'b0;
        repeat (40) tick();
        // Four speed presses: speed 1,2,3,0.
        for (int p = 0; p < 4; p++) begin
            key_n = 1'b0;
            repeat (8) tick();
            key_n = 1'b1;
            repeat (40) tick();
        end
        // Reset while running at led=08.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sw0 = 1'b1;
        n = 0;
        while (led !== 8'h08 && n < 200) begin
            tick();
            n++;
        end
        chk("reach_led08", led, 8'h08);
        rst = 1'b1;
        tick();
        chk("midrst_led", led, 8'h00);
        chk("midrst_mode", {7'd0, mode}, 8'd0);
        rst = 1'b0;
        repeat (40) tick();
        // Random switch, button and occasional reset activity.
        repeat (80) begin
            sw0   = 1'($urandom_range(0, 1));
            key_n = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            rst   = ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0;
            tick();
            rst = 1'b0;
            repeat ($urandom_range(1, 30)) tick();
        end
        key_n = 1'b1;
        repeat (60) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
